// File: rtl/rsa_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// rsa_op_sequencer_if
// Bundles the host byte bus and the modular-exponentiation engine handshake
// of rsa_op_sequencer.
//   Host side   : wr_en, reg_sel, addr, data_i, start, rd_en, rd_addr  (to DUT)
//                 data_o, busy, done, err, k_o                        (from DUT)
//   Engine side : me_base, me_exp, me_mod, me_k, me_start              (from DUT)
//                 me_done, me_result                                   (to DUT)
// modport slave is the sequencer; modport master is the host/engine side.
// ---------------------------------------------------------------------------
interface rsa_op_sequencer_if #(
  parameter int WIDTH  = 256,
  parameter int ADDR_W = 5,
  parameter int K_W    = 9
);
  logic              wr_en;
  logic [1:0]        reg_sel;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_i;
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        data_o;
  logic              busy;
  logic              done;
  logic              err;
  logic [K_W-1:0]    k_o;
  logic [WIDTH-1:0]  me_base;
  logic [WIDTH-1:0]  me_exp;
  logic [WIDTH-1:0]  me_mod;
  logic [K_W-1:0]    me_k;
  logic              me_start;
  logic              me_done;
  logic [WIDTH-1:0]  me_result;

  modport master (
    output wr_en, reg_sel, addr, data_i, start, rd_en, rd_addr, me_done, me_result,
    input  data_o, busy, done, err, k_o, me_base, me_exp, me_mod, me_k, me_start
  );

  modport slave (
    input  wr_en, reg_sel, addr, data_i, start, rd_en, rd_addr, me_done, me_result,
    output data_o, busy, done, err, k_o, me_base, me_exp, me_mod, me_k, me_start
  );
endinterface

// File: rtl/rsa_op_sequencer.sv
// ---------------------------------------------------------------------------
// rsa_op_sequencer
// Control front-end of the modular-exponentiation engine. Loads base, exponent
// and modulus byte-wise from the host, finds the exponent bit length k with an
// MSB-first byte scan, launches the engine, watches it with a watchdog,
// captures the result and serves it back as a registered byte read port.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high, clears all state
//   bus   : rsa_op_sequencer_if.slave (host byte bus + engine handshake)
// ---------------------------------------------------------------------------
module rsa_op_sequencer #(
  parameter int WIDTH   = 256,
  parameter int ADDR_W  = 5,
  parameter int K_W     = 9,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  rsa_op_sequencer_if.slave bus
);
  localparam int NB    = WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LAUNCH, S_RUN, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  base_reg, exp_reg, mod_reg, result_reg;
  logic [WIDTH-1:0]  mod_eff;
  logic [ADDR_W-1:0] idx_reg;
  logic [K_W-1:0]    k_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;
  logic [7:0]        data_o_reg;
  logic [7:0]        exp_bytes [NB];
  logic [7:0]        res_bytes [NB];
  logic              idle_like, wr_ok, wd_hit;
  logic [7:0]        scan_byte;
  logic [K_W-1:0]    k_scan;

  // Byte views used by the scan mux and the read port.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bytes
      assign exp_bytes[gi] = exp_reg[gi*8 +: 8];
      assign res_bytes[gi] = result_reg[gi*8 +: 8];
    end
  endgenerate

  // Position of the highest set bit, 1-based; 0 for a zero byte.
  function automatic logic [3:0] bitlen(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) n = 4'(i + 1);
    end
    return n;
  endfunction

  assign idle_like = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign wr_ok     = idle_like && bus.wr_en && (bus.reg_sel != 2'd0);
  assign scan_byte = exp_bytes[idx_reg];
  assign k_scan    = K_W'({idx_reg, 3'b000}) + K_W'(bitlen(scan_byte));
  assign wd_hit    = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Modulus as it will be after this edge, so a modulus write issued together
  // with start is honoured by the zero-modulus check.
  always_comb begin
    mod_eff = mod_reg;
    if (wr_ok && (bus.reg_sel == 2'd3)) mod_eff[{bus.addr, 3'b000} +: 8] = bus.data_i;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (bus.start) state_next = (mod_eff == '0) ? S_DONE : S_SCAN;
      S_SCAN: begin
        if (scan_byte != 8'd0)    state_next = S_LAUNCH;
        else if (idx_reg == '0)   state_next = S_DONE;
      end
      S_LAUNCH: state_next = S_RUN;
      S_RUN:    if (bus.me_done || wd_hit) state_next = S_DONE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; me_start follows the async-reset state register.
  always_comb begin
    bus.busy     = (state_reg == S_SCAN) || (state_reg == S_LAUNCH) || (state_reg == S_RUN);
    bus.done     = (state_reg == S_DONE);
    bus.me_start = (state_reg == S_LAUNCH);
  end

  // Operand, scan, watchdog, result and read datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_reg   <= '0;
      exp_reg    <= '0;
      mod_reg    <= '0;
      result_reg <= '0;
      k_reg      <= '0;
      idx_reg    <= '1;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      data_o_reg <= 8'd0;
    end else begin
      if (wr_ok) begin
        case (bus.reg_sel)
          2'd1:    base_reg[{bus.addr, 3'b000} +: 8] <= bus.data_i;
          2'd2:    exp_reg[{bus.addr, 3'b000} +: 8]  <= bus.data_i;
          2'd3:    mod_reg[{bus.addr, 3'b000} +: 8]  <= bus.data_i;
          default: ;
        endcase
      end

      if (bus.rd_en) data_o_reg <= res_bytes[bus.rd_addr];

      case (state_reg)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            result_reg <= '0;
            if (mod_eff == '0) begin
              err_reg <= 1'b1;
            end else begin
              err_reg <= 1'b0;
              idx_reg <= '1;
            end
          end
        end
        S_SCAN: begin
          if (scan_byte != 8'd0) begin
            k_reg <= k_scan;
          end else if (idx_reg == '0) begin
            // All-zero exponent: x^0 = 1, engine is never started.
            k_reg      <= '0;
            result_reg <= WIDTH'(1);
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        S_LAUNCH: cnt_reg <= '0;
        S_RUN: begin
          // A completion in the watchdog's last cycle still counts as success.
          if (bus.me_done) begin
            result_reg <= bus.me_result;
          end else if (wd_hit) begin
            err_reg    <= 1'b1;
            result_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_o  = data_o_reg;
  assign bus.err     = err_reg;
  assign bus.k_o     = k_reg;
  assign bus.me_k    = k_reg;
  assign bus.me_base = base_reg;
  assign bus.me_exp  = exp_reg;
  assign bus.me_mod  = mod_reg;
endmodule

// File: tb/tb_rsa_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rsa_op_sequencer
// Drives host writes/reads and plays the engine; predicts k, launch latency,
// status and result from the exponent/modulus values directly.
// ---------------------------------------------------------------------------
module tb_rsa_op_sequencer;
  localparam int WIDTH   = 256;
  localparam int ADDR_W  = 5;
  localparam int K_W     = 9;
  localparam int TIMEOUT = 16;
  localparam int NB      = WIDTH / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rsa_op_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .K_W(K_W)) bus ();

  rsa_op_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .K_W(K_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [K_W-1:0] k_model = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_wide();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // k = index of highest set bit + 1
  function automatic int ref_k(input logic [WIDTH-1:0] e);
    for (int i = WIDTH - 1; i >= 0; i--) if (e[i]) return i + 1;
    return 0;
  endfunction

  // cycles from start to me_start (or to done for a zero exponent)
  function automatic int ref_lat(input int k);
    return (k == 0) ? (NB + 1) : (2 + (WIDTH - k) / 8);
  endfunction

  function automatic longint modexp(input longint b, input longint e, input longint m);
    longint r, bb, ee;
    r = 1; bb = b % m; ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >> 1;
    end
    return r;
  endfunction

  task automatic write_byte(input logic [1:0] sel, input int a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.reg_sel = sel; bus.addr = ADDR_W'(a); bus.data_i = d;
    tick();
    bus.wr_en = 1'b0; bus.reg_sel = 2'd0;
  endtask

  task automatic load_reg(input logic [1:0] sel, input logic [WIDTH-1:0] v);
    for (int i = 0; i < NB; i++) write_byte(sel, i, v[i*8 +: 8]);
  endtask

  task automatic read_all(input string name, input logic [WIDTH-1:0] expv);
    for (int a = 0; a < NB; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(a);
      tick();
      total++;
      if (bus.data_o !== expv[a*8 +: 8]) begin
        bad++;
        $display("FAIL %s rd[%0d]: got %h want %h", name, a, bus.data_o, expv[a*8 +: 8]);
      end
    end
    bus.rd_en = 1'b0;
  endtask

  // Full operation: load, start, engine play, status and result check.
  task automatic do_operation(input string name, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] m,
                              input int dly, input logic [WIDTH-1:0] r, input bit respond);
    int n, kk, lat;
    bit launch, exp_err;
    logic [WIDTH-1:0] exp_res;
    load_reg(2'd1, b); load_reg(2'd2, ex); load_reg(2'd3, m);
    kk = ref_k(ex);
    if (m == '0) begin
      launch = 0; exp_err = 1; exp_res = '0; lat = 1;
    end else begin
      k_model = K_W'(kk);
      lat = ref_lat(kk);
      if (kk == 0) begin
        launch = 0; exp_err = 0; exp_res = WIDTH'(1);
      end else begin
        launch = 1; exp_err = !respond; exp_res = respond ? r : '0;
      end
    end
    $display("op %s: k=%0d lat=%0d launch=%0d err=%0d", name, kk, lat, launch, exp_err);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (!bus.me_start && !bus.done && n < 300) begin tick(); n++; end
    if (launch) begin
      total++;
      if (bus.me_start !== 1'b1 || n != lat) begin
        bad++; $display("FAIL %s launch: me_start=%b after %0d cycles, want 1 after %0d", name, bus.me_start, n, lat);
      end
      total++;
      if (bus.k_o !== k_model || bus.me_k !== k_model) begin
        bad++; $display("FAIL %s k: k_o=%0d me_k=%0d want %0d", name, bus.k_o, bus.me_k, k_model);
      end
      total++;
      if (bus.me_base !== b || bus.me_exp !== ex || bus.me_mod !== m) begin
        bad++; $display("FAIL %s operands: exp got %h want %h", name, bus.me_exp, ex);
      end
      tick();
      total++;
      if (bus.me_start !== 1'b0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL %s run: me_start=%b busy=%b want 0 1", name, bus.me_start, bus.busy);
      end
      if (respond) begin
        for (int i = 1; i < dly; i++) begin
          bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'($urandom);
          tick();
          total++;
          if (bus.data_o !== 8'd0) begin
            bad++; $display("FAIL %s busy_read: got %h want 00", name, bus.data_o);
          end
        end
        bus.rd_en = 1'b0;
        bus.me_done = 1'b1; bus.me_result = r;
        tick();
        bus.me_done = 1'b0; bus.me_result = rand_wide();
      end else begin
        n = 0;
        while (!bus.done && n < 100) begin tick(); n++; end
        total++;
        if (bus.done !== 1'b1 || n != TIMEOUT) begin
          bad++; $display("FAIL %s watchdog: done=%b after %0d more RUN cycles, want 1 after %0d", name, bus.done, n, TIMEOUT);
        end
      end
    end else begin
      total++;
      if (bus.done !== 1'b1 || n != lat) begin
        bad++; $display("FAIL %s no_launch: done=%b me_start=%b after %0d cycles, want done after %0d", name, bus.done, bus.me_start, n, lat);
      end
    end
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== exp_err) begin
      bad++; $display("FAIL %s status: done=%b busy=%b err=%b want 1 0 %b", name, bus.done, bus.busy, bus.err, exp_err);
    end
    total++;
    if (bus.k_o !== k_model) begin
      bad++; $display("FAIL %s k_final: got %0d want %0d", name, bus.k_o, k_model);
    end
    read_all(name, exp_res);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({bus.busy, bus.done, bus.err, bus.me_start} !== 4'b0000 || bus.k_o !== '0 || bus.data_o !== 8'd0) begin
      bad++; $display("FAIL reset_flags: busy=%b done=%b err=%b me_start=%b k=%0d data_o=%h want all 0",
                      bus.busy, bus.done, bus.err, bus.me_start, bus.k_o, bus.data_o);
    end
    total++;
    if (bus.me_base !== '0 || bus.me_exp !== '0 || bus.me_mod !== '0) begin
      bad++; $display("FAIL reset_operands: nonzero operand after reset, exp=%h", bus.me_exp);
    end
    reset = 1'b0;
    tick();
    read_all("reset", '0);
  endtask

  task automatic test_known();
    logic [WIDTH-1:0] r;
    logic [7:0] want [3];
    r = WIDTH'(modexp(4, 13, 497));
    do_operation("known", WIDTH'(4), WIDTH'(13), WIDTH'(497), 5, r, 1'b1);
    want[0] = 8'hBD; want[1] = 8'h01; want[2] = 8'h00;
    for (int a = 0; a < 3; a++) begin
      bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(a);
      tick();
      total++;
      if (bus.data_o !== want[a]) begin
        bad++; $display("FAIL known_byte[%0d]: got %h want %h", a, bus.data_o, want[a]);
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_top_bit();
    logic [WIDTH-1:0] ex;
    ex = '0; ex[WIDTH-1] = 1'b1;
    do_operation("top_bit", rand_wide(), ex, rand_wide() | WIDTH'(1), 3, rand_wide(), 1'b1);
    total++;
    if (bus.k_o !== 9'd256) begin
      bad++; $display("FAIL top_bit_k: got %0d want 256", bus.k_o);
    end
  endtask

  task automatic test_zero_exp();
    do_operation("zero_exp", rand_wide(), '0, WIDTH'(7), 1, '0, 1'b1);
    bus.rd_en = 1'b1; bus.rd_addr = '0;
    tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.data_o !== 8'h01 || bus.err !== 1'b0) begin
      bad++; $display("FAIL zero_exp_result: byte0=%h err=%b want 01 0", bus.data_o, bus.err);
    end
  endtask

  task automatic test_zero_mod();
    do_operation("zero_mod", rand_wide(), rand_wide() | WIDTH'(1), '0, 1, '0, 1'b1);
    total++;
    if (bus.err !== 1'b1) begin
      bad++; $display("FAIL zero_mod_err: got %b want 1", bus.err);
    end
  endtask

  task automatic test_timeout();
    do_operation("timeout", rand_wide(), rand_wide() | WIDTH'(1), rand_wide() | WIDTH'(1), 0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ex, r;
    int n, kk;
    r = rand_wide();
    ex = WIDTH'(5);
    load_reg(2'd2, ex);
    // Write and start in the same cycle: the scan must see the new byte.
    ex[20*8 +: 8] = 8'h01;
    kk = ref_k(ex);
    k_model = K_W'(kk);
    bus.wr_en = 1'b1; bus.reg_sel = 2'd2; bus.addr = ADDR_W'(20); bus.data_i = 8'h01; bus.start = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.reg_sel = 2'd0; bus.start = 1'b0;
    n = 1;
    while (!bus.me_start && n < 300) begin tick(); n++; end
    $display("op b2b: k=%0d lat=%0d", kk, ref_lat(kk));
    total++;
    if (bus.me_start !== 1'b1 || n != ref_lat(kk) || bus.k_o !== k_model) begin
      bad++; $display("FAIL b2b_launch: me_start=%b n=%0d k=%0d want 1 %0d %0d", bus.me_start, n, bus.k_o, ref_lat(kk), k_model);
    end
    tick();
    bus.me_done = 1'b1; bus.me_result = r;
    tick();
    bus.me_done = 1'b0;
    // Engine completion outside RUN must not touch the result.
    bus.me_done = 1'b1; bus.me_result = ~r;
    tick();
    bus.me_done = 1'b0;
    bus.rd_en = 1'b1; bus.rd_addr = '0;
    tick();
    bus.rd_en = 1'b0;
    total++;
    if (bus.data_o !== r[7:0] || bus.done !== 1'b1) begin
      bad++; $display("FAIL b2b_stray_done: byte0=%h done=%b want %h 1", bus.data_o, bus.done, r[7:0]);
    end
    // Start held high in DONE relaunches at once.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      bad++; $display("FAIL b2b_relaunch: busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    n = 0;
    while (!bus.me_start && n < 300) begin tick(); n++; end
    tick();
    bus.me_done = 1'b1; bus.me_result = r;
    tick();
    bus.me_done = 1'b0;
    total++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
      bad++; $display("FAIL b2b_second: done=%b err=%b want 1 0", bus.done, bus.err);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ex, m;
    int len;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(0, WIDTH);
      if (len == 0) ex = '0;
      else begin
        ex = rand_wide() & ({WIDTH{1'b1}} >> (WIDTH - len));
        ex[len-1] = 1'b1;
      end
      m = rand_wide() | WIDTH'(2);
      if ($urandom_range(0, 7) == 0) m = '0;
      do_operation($sformatf("rand%0d", it), rand_wide(), ex, m,
                   $urandom_range(1, 12), rand_wide(), $urandom_range(0, 4) != 0);
    end
  endtask

  task automatic test_run_ignored();
    logic [WIDTH-1:0] b, ex;
    b = rand_wide();
    ex = '0; ex[WIDTH-1] = 1'b1;
    load_reg(2'd1, b); load_reg(2'd2, ex); load_reg(2'd3, rand_wide() | WIDTH'(1));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); tick();                      // LAUNCH, then RUN
    write_byte(2'd1, 0, ~b[7:0]);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    total++;
    if (bus.me_base !== b || bus.busy !== 1'b1 || bus.me_start !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL run_ignored: base0=%h busy=%b me_start=%b done=%b want %h 1 0 0",
                      bus.me_base[7:0], bus.busy, bus.me_start, bus.done, b[7:0]);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.me_base !== '0) begin
      bad++; $display("FAIL run_reset: busy=%b done=%b base0=%h want 0 0 00", bus.busy, bus.done, bus.me_base[7:0]);
    end
    tick();
    reset = 1'b0;
    k_model = '0;
    read_all("run_reset", '0);
    // Reset in LAUNCH must drop me_start without waiting for an edge.
    load_reg(2'd2, ex); load_reg(2'd3, WIDTH'(3));
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    total++;
    if (bus.me_start !== 1'b1) begin
      bad++; $display("FAIL launch_pre_reset: me_start=%b want 1", bus.me_start);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.me_start !== 1'b0) begin
      bad++; $display("FAIL launch_async_reset: me_start=%b want 0", bus.me_start);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.reg_sel = 2'd0; bus.addr = '0; bus.data_i = 8'd0;
    bus.start = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    bus.me_done = 1'b0; bus.me_result = '0;
    test_reset();
    test_known();
    test_top_bit();
    test_zero_exp();
    test_zero_mod();
    test_timeout();
    test_back_to_back();
    test_random();
    test_run_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
